// File: rtl/line_fetch_sched.sv
// Ping-pong line prefetcher for a 1280x720 scan-out: bursts the next visible line
// from the frame buffer into one half while the other half streams out with h_count.
module line_fetch_sched #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int BURST_LEN   = 64,
  parameter int LINE_STRIDE = 1280,
  parameter int FB_BASE     = 0,
  parameter int ADDR_W      = 24,
  parameter int PIX_W       = 24
) (
  input  logic              rfr_clk,
  input  logic              reset_n,
  input  logic [11:0]       h_count,
  input  logic [11:0]       v_count,
  input  logic              video_on,
  input  logic              enable,
  input  logic              clear_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rdata_valid,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_out,
  output logic              busy,
  output logic              underrun,
  output logic              fetch_miss
);

  localparam int N_BURST = H_ACTIVE / BURST_LEN;
  localparam int BW      = (N_BURST > 1) ? $clog2(N_BURST) : 1;
  localparam int KW      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int XW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t            state;
  logic [11:0]       line;
  logic [BW-1:0]     burst;
  logic [KW-1:0]     beat;
  logic [1:0]        line_ready;
  logic [1:0]        ready_nxt;
  logic              line_bad;

  logic [PIX_W-1:0]  buf0 [H_ACTIVE];
  logic [PIX_W-1:0]  buf1 [H_ACTIVE];

  logic              trig_hit;
  logic [11:0]       trig_line;
  logic              last_beat;
  logic              last_burst;
  logic              fetch_done;
  logic [XW-1:0]     wr_idx;
  logic              rd_sel;
  logic              sol_chk;
  logic              eol_clr;
  logic              bad_now;
  logic              in_active;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [11:0] l, input logic [BW-1:0] bi);
    return ADDR_W'(32'(FB_BASE) + 32'(l) * 32'(LINE_STRIDE) + 32'(bi) * 32'(BURST_LEN));
  endfunction

  // Lines 0..V_ACTIVE-2 prefetch the following line; the last line wraps to line 0.
  assign trig_hit   = (h_count == 12'(H_ACTIVE)) && (32'(v_count) < 32'(V_ACTIVE));
  assign trig_line  = (32'(v_count) == 32'(V_ACTIVE - 1)) ? '0 : v_count + 12'd1;
  assign last_beat  = (beat == KW'(BURST_LEN - 1));
  assign last_burst = (burst == BW'(N_BURST - 1));
  assign fetch_done = (state == DATA) && mem_rdata_valid && last_beat && last_burst;
  assign wr_idx     = XW'(32'(burst) * 32'(BURST_LEN) + 32'(beat));

  assign rd_sel    = v_count[0];
  assign in_active = (h_count < 12'(H_ACTIVE));
  assign sol_chk   = video_on && (h_count == 12'd0);
  assign eol_clr   = video_on && (h_count == 12'(H_ACTIVE - 1));
  // The start-of-line verdict must also blank pixel 0 itself, before line_bad is registered.
  assign bad_now   = sol_chk ? !line_ready[rd_sel] : line_bad;
  assign busy      = (state != IDLE);

  always_comb begin
    ready_nxt = line_ready;
    if (fetch_done) ready_nxt[line[0]] = 1'b1;
    if (eol_clr)    ready_nxt[rd_sel]  = 1'b0;
  end

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      line       <= '0;
      burst      <= '0;
      beat       <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      line_ready <= '0;
      line_bad   <= 1'b0;
      underrun   <= 1'b0;
      fetch_miss <= 1'b0;
      pix_out    <= '0;
    end else begin
      line_ready <= ready_nxt;

      if (sol_chk) line_bad <= !line_ready[rd_sel];

      if (sol_chk && !line_ready[rd_sel]) underrun <= 1'b1;
      else if (clear_err)                 underrun <= 1'b0;

      if (trig_hit && state != IDLE) fetch_miss <= 1'b1;
      else if (clear_err)            fetch_miss <= 1'b0;

      if (video_on && in_active && !bad_now)
        pix_out <= rd_sel ? buf1[h_count[XW-1:0]] : buf0[h_count[XW-1:0]];
      else
        pix_out <= '0;

      case (state)
        IDLE: begin
          if (trig_hit && enable) begin
            line     <= trig_line;
            burst    <= '0;
            beat     <= '0;
            mem_addr <= addr_of(trig_line, '0);
            mem_req  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (mem_rdata_valid) begin
            if (last_beat) begin
              beat <= '0;
              if (last_burst) begin
                state <= IDLE;
              end else begin
                burst    <= burst + 1'b1;
                mem_addr <= addr_of(line, burst + 1'b1);
                mem_req  <= 1'b1;
                state    <= REQ;
              end
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge rfr_clk) begin
    if (state == DATA && mem_rdata_valid) begin
      if (line[0]) buf1[wr_idx] <= mem_rdata;
      else         buf0[wr_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_line_fetch_sched.sv
// Directed bench for line_fetch_sched with a burst memory model returning data equal to address.
module tb_line_fetch_sched;

  logic        rfr_clk = 1'b0;
  logic        reset_n;
  logic [11:0] h_count;
  logic [11:0] v_count;
  logic        video_on;
  logic        enable;
  logic        clear_err;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rdata_valid;
  logic [23:0] mem_rdata;
  logic [23:0] pix_out;
  logic        busy;
  logic        underrun;
  logic        fetch_miss;

  line_fetch_sched #(
    .H_ACTIVE(1280), .V_ACTIVE(720), .BURST_LEN(64), .LINE_STRIDE(1280),
    .FB_BASE(0), .ADDR_W(24), .PIX_W(24)
  ) dut (
    .rfr_clk(rfr_clk), .reset_n(reset_n), .h_count(h_count), .v_count(v_count),
    .video_on(video_on), .enable(enable), .clear_err(clear_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .pix_out(pix_out), .busy(busy), .underrun(underrun), .fetch_miss(fetch_miss)
  );

  always #5 rfr_clk = ~rfr_clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Memory model: grants a pending request, then streams 64 beats of data == address.
  bit          gnt_en = 1'b1;
  bit          valid_en = 1'b1;
  bit          pend = 1'b0;
  int          beats_left = 0;
  int          beat_no = 0;
  int          total_beats = 0;
  logic [23:0] cur_addr = '0;
  logic [23:0] g_addr = '0;
  logic [23:0] grant_q[$];

  initial begin
    mem_gnt = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge rfr_clk);
      mem_gnt = 1'b0;
      mem_rdata_valid = 1'b0;
      if (pend) begin
        pend = 1'b0;
        beats_left = 64;
        cur_addr = g_addr;
      end
      if (beats_left > 0 && valid_en) begin
        mem_rdata_valid = 1'b1;
        mem_rdata = cur_addr;
        beat_no = 64 - beats_left;
        cur_addr = cur_addr + 24'd1;
        beats_left--;
        total_beats++;
      end else if (beats_left == 0 && mem_req === 1'b1 && gnt_en) begin
        mem_gnt = 1'b1;
        g_addr = mem_addr;
        pend = 1'b1;
        grant_q.push_back(mem_addr);
      end
    end
  end

  task automatic tick();
    @(posedge rfr_clk);
    #1;
  endtask

  task automatic drv(input int h, input int v, input bit von);
    h_count = 12'(h);
    v_count = 12'(v);
    video_on = von;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic show_line(input int v, input int base, input bit expect_zero, input bit clr_at0);
    for (int n = 0; n < 1280; n++) begin
      drv(n, v, 1'b1);
      clear_err = clr_at0 && (n == 0);
      tick();
      clear_err = 1'b0;
      check($sformatf("pix_l%0d_h%0d", v, n), pix_out, expect_zero ? 0 : base + n);
    end
    drv(1300, v, 1'b0);
    tick();
    check($sformatf("pix_blank_l%0d", v), pix_out, 0);
  endtask

  initial begin
    int nq;
    int n;
    reset_n = 1'b0;
    enable = 1'b1;
    clear_err = 1'b0;
    drv(1300, 4, 1'b0);
    repeat (3) tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_fetch_miss", fetch_miss, 0);
    check("rst_pix", pix_out, 0);
    reset_n = 1'b1;
    tick();

    // Line 5 prefetch, first request held without grant
    gnt_en = 1'b0;
    grant_q.delete();
    total_beats = 0;
    drv(1280, 4, 1'b0);
    tick();
    drv(1300, 4, 1'b0);
    check("req1_mem_req", mem_req, 1);
    check("req1_addr", mem_addr, 6400);
    check("req1_busy", busy, 1);
    repeat (4) tick();
    check("hold_mem_req", mem_req, 1);
    check("hold_addr", mem_addr, 6400);
    gnt_en = 1'b1;
    wait_idle("idle_fetch5");
    check("n_bursts", grant_q.size(), 20);
    for (int i = 0; i < 20; i++)
      check($sformatf("burst_addr%0d", i), (i < grant_q.size()) ? grant_q[i] : 24'hFFFFFF, 6400 + 64 * i);
    check("n_beats", total_beats, 1280);
    check("req_low_idle", mem_req, 0);
    show_line(5, 6400, 1'b0, 1'b0);
    check("no_underrun_l5", underrun, 0);

    // Wrap from the last line to line 0
    drv(1280, 719, 1'b0);
    tick();
    drv(1300, 719, 1'b0);
    check("wrap_req", mem_req, 1);
    check("wrap_addr", mem_addr, 0);
    wait_idle("idle_fetch0");
    show_line(0, 0, 1'b0, 1'b0);
    check("no_underrun_l0", underrun, 0);

    // enable=0 drops the trigger silently
    enable = 1'b0;
    drv(1280, 4, 1'b0);
    tick();
    drv(1300, 4, 1'b0);
    enable = 1'b1;
    check("dis_busy", busy, 0);
    check("dis_req", mem_req, 0);
    check("dis_miss", fetch_miss, 0);

    // Grant withheld for all of line 4: line 5 underruns; clear_err loses to the new error
    gnt_en = 1'b0;
    drv(1280, 4, 1'b0);
    tick();
    drv(1300, 4, 1'b0);
    repeat (100) tick();
    check("stall_busy", busy, 1);
    show_line(5, 0, 1'b1, 1'b1);
    check("underrun_set", underrun, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("underrun_clr", underrun, 0);
    gnt_en = 1'b1;
    wait_idle("idle_after_underrun");

    // Data stalled: trigger on line 5 while still fetching -> fetch_miss, no new request
    valid_en = 1'b0;
    drv(1280, 4, 1'b0);
    tick();
    drv(1300, 4, 1'b0);
    repeat (5) tick();
    nq = grant_q.size();
    drv(1280, 5, 1'b0);
    tick();
    drv(1300, 5, 1'b0);
    repeat (5) tick();
    check("miss_set", fetch_miss, 1);
    check("miss_no_grant", grant_q.size(), nq);
    check("miss_no_req", mem_req, 0);
    check("miss_busy", busy, 1);
    check("miss_no_underrun", underrun, 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("miss_clr", fetch_miss, 0);
    valid_en = 1'b1;
    wait_idle("idle_after_miss");

    // Reset during beat 30 of the first burst
    drv(1280, 4, 1'b0);
    tick();
    drv(1300, 4, 1'b0);
    n = 0;
    while (!(mem_rdata_valid === 1'b1 && beat_no == 30) && n < 300) begin
      tick();
      n++;
    end
    check("beat30_reached", n < 300, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    tick();
    reset_n = 1'b1;
    nq = grant_q.size();
    repeat (80) tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_req", mem_req, 0);
    check("post_rst_no_grant", grant_q.size(), nq);
    drv(0, 5, 1'b1);
    tick();
    drv(1300, 5, 1'b0);
    check("post_rst_underrun", underrun, 1);
    check("post_rst_pix", pix_out, 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    drv(1280, 4, 1'b0);
    tick();
    drv(1300, 4, 1'b0);
    check("restart_req", mem_req, 1);
    check("restart_addr", mem_addr, 6400);
    wait_idle("idle_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
